tff_count_seq: RTL and testbench

//  Sequencer for a bank of WIDTH tFlipFlop cells used as a synchronous counter.
//  - Drives the bank's toggle inputs (t_vec) and reads back the bank outputs (q_fb).
//  - Presets the bank in one cycle, counts up or down to a target, then pulses done.
//  - Provides a start/busy/done handshake to the upstream controller.

---
 rtl/tff_seq_pkg.sv | 27 ++
 rtl/tff_count_seq_if.sv | 17 +
 rtl/tff_count_seq_toggle_gen.sv | 23 ++
 rtl/tff_count_seq.sv | 131 +++++++++++++
 tb/tb_tff_count_seq.sv | 224 ++++++++++++++++++++++
 5 files changed

// File: rtl/tff_seq_pkg.sv
// Shared types and constants for the tFlipFlop bank counter sequencer.
package tff_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_PRESET = 2'd1,
        ST_RUN    = 2'd2,
        ST_DONE   = 2'd3
    } state_e;

    localparam logic DIR_UP    = 1'b0;
    localparam logic DIR_DOWN  = 1'b1;
    localparam int   MAX_WIDTH = 16;

    // One count step of a binary value in the given direction.
    function automatic logic [MAX_WIDTH-1:0] step_value(input logic [MAX_WIDTH-1:0] v,
                                                        input logic d);
        logic [MAX_WIDTH-1:0] r;
        if (d == DIR_DOWN) begin
            r = v - 16'd1;
        end else begin
            r = v + 16'd1;
        end
        return r;
    endfunction

endpackage

// File: rtl/tff_count_seq_if.sv
// Control handshake plus bank toggle/feedback bundle of the counter sequencer.
interface tff_count_seq_if #(parameter int WIDTH = 4);
    logic             start;
    logic             abort;
    logic             dir;
    logic [WIDTH-1:0] limit;
    logic [WIDTH-1:0] q_fb;
    logic [WIDTH-1:0] t_vec;
    logic             busy;
    logic             done;
    logic             err;

    modport master (output start, abort, dir, limit, q_fb,
                    input  t_vec, busy, done, err);
    modport slave  (input  start, abort, dir, limit, q_fb,
                    output t_vec, busy, done, err);
endinterface

// File: rtl/tff_count_seq_toggle_gen.sv
// Toggle pattern for one up/down count step of a tFlipFlop bank.
// Bit i toggles when all lower bits are 1 (up) or all lower bits are 0 (down).
module tff_toggle_gen #(parameter int WIDTH = 4) (
    input  logic [WIDTH-1:0] q,
    input  logic             dir,
    output logic [WIDTH-1:0] t
);
    import tff_seq_pkg::*;

    logic [WIDTH-1:0] bits_s;
    logic             chain_s;

    // Ripple carry/borrow chain over the (optionally inverted) bank value.
    always_comb begin
        bits_s  = (dir == DIR_DOWN) ? ~q : q;
        chain_s = 1'b1;
        t       = {WIDTH{1'b0}};
        for (int i = 0; i < WIDTH; i++) begin
            t[i]    = chain_s;
            chain_s = chain_s & bits_s[i];
        end
    end
endmodule

// File: rtl/tff_count_seq.sv
// Sequencer that presets a bank of tFlipFlop cells and counts it to a target.
// Optional shadow-value mismatch checker enabled by macro TFF_SEQ_CHECK_EN.
module tff_count_seq #(parameter int WIDTH = 4) (
    input  logic            clk,
    input  logic            rst,
    tff_count_seq_if.slave  bus
);
    import tff_seq_pkg::*;

    state_e           state_r;
    state_e           state_nx_s;
    logic             dir_r;
    logic [WIDTH-1:0] limit_r;
    logic             busy_r;
    logic             done_r;
    logic [WIDTH-1:0] step_t_s;
    logic [WIDTH-1:0] preset_s;
    logic [WIDTH-1:0] t_vec_s;
    logic             at_target_s;
    logic             accept_s;

    tff_toggle_gen #(.WIDTH(WIDTH)) u_toggle_gen (
        .q   (bus.q_fb),
        .dir (dir_r),
        .t   (step_t_s)
    );

    // Preset value, target detection and start acceptance.
    always_comb begin
        preset_s = (dir_r == DIR_DOWN) ? limit_r : {WIDTH{1'b0}};
        if (dir_r == DIR_DOWN) begin
            at_target_s = (bus.q_fb == {WIDTH{1'b0}});
        end else begin
            at_target_s = (bus.q_fb == limit_r);
        end
        accept_s = (state_r == ST_IDLE) && bus.start && !bus.abort;
    end

    // Next state and combinational toggle vector; abort and rst force zero toggles.
    always_comb begin
        state_nx_s = state_r;
        t_vec_s    = {WIDTH{1'b0}};
        if (rst) begin
            state_nx_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    state_nx_s = accept_s ? ST_PRESET : ST_IDLE;
                end
                ST_PRESET: begin
                    if (bus.abort) begin
                        state_nx_s = ST_IDLE;
                    end else begin
                        t_vec_s    = bus.q_fb ^ preset_s;
                        state_nx_s = ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (bus.abort) begin
                        state_nx_s = ST_IDLE;
                    end else if (at_target_s) begin
                        state_nx_s = ST_DONE;
                    end else begin
                        t_vec_s    = step_t_s;
                    end
                end
                ST_DONE: begin
                    state_nx_s = ST_IDLE;
                end
                default: begin
                    state_nx_s = ST_IDLE;
                end
            endcase
        end
    end

    // State, latched request and registered status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
            dir_r   <= DIR_UP;
            limit_r <= {WIDTH{1'b0}};
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_nx_s;
            busy_r  <= (state_nx_s == ST_PRESET) || (state_nx_s == ST_RUN);
            done_r  <= (state_nx_s == ST_DONE);
            if (accept_s) begin
                dir_r   <= bus.dir;
                limit_r <= bus.limit;
            end
        end
    end

    assign bus.t_vec = t_vec_s;
    assign bus.busy  = busy_r;
    assign bus.done  = done_r;

`ifdef TFF_SEQ_CHECK_EN
    logic [WIDTH-1:0] exp_r;
    logic             err_r;

    // Shadow of the expected bank value and sticky mismatch flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            exp_r <= {WIDTH{1'b0}};
            err_r <= 1'b0;
        end else begin
            if (accept_s) begin
                err_r <= 1'b0;
            end else if ((state_r == ST_RUN) && (bus.q_fb != exp_r)) begin
                err_r <= 1'b1;
            end else begin
                err_r <= err_r;
            end
            if ((state_r == ST_PRESET) && !bus.abort) begin
                exp_r <= preset_s;
            end else if ((state_r == ST_RUN) && !bus.abort && !at_target_s) begin
                exp_r <= WIDTH'(step_value(MAX_WIDTH'(exp_r), dir_r));
            end else begin
                exp_r <= exp_r;
            end
        end
    end

    assign bus.err = err_r;
`else
    assign bus.err = 1'b0;
`endif
endmodule

// File: tb/tb_tff_count_seq.sv
// Bench for tff_count_seq with a 4-cell tFlipFlop bank model and a done scoreboard.
module tb_tff_count_seq;
    logic       clk;
    logic       rst;
    logic [3:0] bank;
    logic       bank_load;
    logic [3:0] bank_load_val;
    logic       stuck;
    int         cyc;
    int         n_checks;
    int         n_errors;
    int         c0;

    typedef struct {
        logic [3:0] q;
        int         cyc;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;

    tff_count_seq_if #(.WIDTH(4)) bus ();

    tff_count_seq #(.WIDTH(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    assign bus.q_fb = stuck ? (bank & 4'b1011) : bank;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Cycle counter for latency checks.
    always @(posedge clk) cyc <= cyc + 1;

    // Bank of four T flip-flops, with a bench-side parallel load.
    always @(posedge clk) begin
        if (bank_load) bank <= bank_load_val;
        else if (rst)  bank <= 4'b0000;
        else           bank <= bank ^ bus.t_vec;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every done pulse must match the oldest expected completion.
    always @(negedge clk) begin
        if (!rst && bus.done) begin
            if (sb_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected_done: got done=1 at cycle %0d expected no done", cyc);
            end else begin
                mon_e = sb_q.pop_front();
                check("done_cycle", cyc, mon_e.cyc);
                check("done_bank", {28'd0, bank}, {28'd0, mon_e.q});
                check("done_busy", {31'd0, bus.busy}, 32'd0);
            end
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic load_bank(input logic [3:0] v);
        bank_load     = 1'b1;
        bank_load_val = v;
        tick();
        bank_load     = 1'b0;
    endtask

    // Issue a start and return the cycle number of the PRESET cycle.
    task automatic do_start(input logic d, input logic [3:0] lim, output int c);
        bus.dir   = d;
        bus.limit = lim;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        c = cyc;
    endtask

    task automatic wait_done(input string name, input int max);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < max && !seen; i++) begin
            tick();
            if (bus.done) seen = 1'b1;
        end
        n_checks++;
        if (!seen) begin
            n_errors++;
            $display("FAIL %s: got no done within %0d cycles expected done", name, max);
        end
    endtask

    initial begin
        cyc           = 0;
        n_checks      = 0;
        n_errors      = 0;
        rst           = 1'b1;
        stuck         = 1'b0;
        bank_load     = 1'b0;
        bank_load_val = 4'b0000;
        bus.start     = 1'b1;
        bus.abort     = 1'b0;
        bus.dir       = 1'b0;
        bus.limit     = 4'd7;

        // Reset with start held high.
        tick();
        tick();
        check("rst_t_vec", {28'd0, bus.t_vec}, 32'd0);
        check("rst_busy",  {31'd0, bus.busy}, 32'd0);
        check("rst_done",  {31'd0, bus.done}, 32'd0);
        check("rst_err",   {31'd0, bus.err},  32'd0);
        rst       = 1'b0;
        bus.start = 1'b0;
        tick();
        check("post_rst_busy", {31'd0, bus.busy}, 32'd0);

        // Up to 5 starting from bank 1011.
        load_bank(4'b1011);
        do_start(1'b0, 4'd5, c0);
        check("up5_preset_t", {28'd0, bus.t_vec}, 32'hb);
        check("up5_busy", {31'd0, bus.busy}, 32'd1);
        sb_q.push_back('{q: 4'd5, cyc: c0 + 7});
        for (int k = 0; k < 6; k++) begin
            tick();
            check("up5_bank", {28'd0, bank}, k);
        end
        wait_done("up5_done", 5);
        repeat (3) tick();
        check("up5_hold", {28'd0, bank}, 32'd5);
        check("up5_idle_busy", {31'd0, bus.busy}, 32'd0);

        // Down from 9 (bank currently 5).
        do_start(1'b1, 4'd9, c0);
        check("dn9_preset_t", {28'd0, bus.t_vec}, 32'hc);
        sb_q.push_back('{q: 4'd0, cyc: c0 + 11});
        tick();
        check("dn9_bank_preset", {28'd0, bank}, 32'd9);
        wait_done("dn9_done", 20);
        check("dn9_final", {28'd0, bank}, 32'd0);

        // Up with limit 0 from bank 0110.
        load_bank(4'b0110);
        do_start(1'b0, 4'd0, c0);
        check("lim0_preset_t", {28'd0, bus.t_vec}, 32'h6);
        sb_q.push_back('{q: 4'd0, cyc: c0 + 2});
        tick();
        check("lim0_run_t", {28'd0, bus.t_vec}, 32'd0);
        check("lim0_run_busy", {31'd0, bus.busy}, 32'd1);
        wait_done("lim0_done", 5);

        // Abort at bank 3 while counting up to 12.
        load_bank(4'b0000);
        do_start(1'b0, 4'd12, c0);
        repeat (4) tick();
        check("abort_bank_before", {28'd0, bank}, 32'd3);
        bus.abort = 1'b1;
        #1;
        check("abort_t_vec", {28'd0, bus.t_vec}, 32'd0);
        tick();
        bus.abort = 1'b0;
        check("abort_busy", {31'd0, bus.busy}, 32'd0);
        check("abort_bank_after", {28'd0, bank}, 32'd3);
        repeat (4) tick();
        check("abort_bank_hold", {28'd0, bank}, 32'd3);

        // Start and abort together in IDLE.
        bus.start = 1'b1;
        bus.abort = 1'b1;
        bus.limit = 4'd4;
        tick();
        check("sa_busy", {31'd0, bus.busy}, 32'd0);
        check("sa_t_vec", {28'd0, bus.t_vec}, 32'd0);
        bus.start = 1'b0;
        bus.abort = 1'b0;
        tick();
        check("sa_busy2", {31'd0, bus.busy}, 32'd0);
        check("sa_bank", {28'd0, bank}, 32'd3);

`ifdef TFF_SEQ_CHECK_EN
        // Bit 2 of the feedback stuck at 0 while counting up to 7.
        load_bank(4'b0000);
        stuck = 1'b1;
        do_start(1'b0, 4'd7, c0);
        repeat (4) tick();
        check("chk_err_clean", {31'd0, bus.err}, 32'd0);
        repeat (2) tick();
        check("chk_err_set", {31'd0, bus.err}, 32'd1);
        repeat (2) tick();
        check("chk_err_sticky", {31'd0, bus.err}, 32'd1);
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        stuck     = 1'b0;
        check("chk_abort_busy", {31'd0, bus.busy}, 32'd0);
        check("chk_err_idle", {31'd0, bus.err}, 32'd1);
        do_start(1'b0, 4'd2, c0);
        check("chk_err_cleared", {31'd0, bus.err}, 32'd0);
        sb_q.push_back('{q: 4'd2, cyc: c0 + 4});
        wait_done("chk_done", 8);
        check("chk_err_final", {31'd0, bus.err}, 32'd0);
`else
        check("err_tied", {31'd0, bus.err}, 32'd0);
`endif

        repeat (3) tick();
        check("sb_empty", sb_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
